seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
// - Inverse of the 7-seg LUT encoder. Monitors a multiplexed, active-low 7-segment bus
//   (segments + per-digit anode enables) and recovers the hex nibble shown on each digit.
// - Sits beside the display driver as a self-check and readback path for the digital clock.
// - Per-digit change events are reported over a valid/ready stream.
// PARAMETERS
// - NUM_DIGITS     6  digits on the scanned display, 1..8
// - STABLE_CYCLES  4  consecutive identical samples required before capture, >=1
// PORTS
// - clk           in   1             single system clock, rising edge
// - reset         in   1             synchronous, active-high
// - iSEG          in   7             segments {g,f,e,d,c,b,a}, active low
// - iAN           in   NUM_DIGITS    anode enables, active low, one-hot-low when a digit is driven
// - iCLR_ERR      in   1             clears oERR and oOVF
// - iEV_READY     in   1             consumer accepts the event
// - oDIGITS       out  4*NUM_DIGITS  decoded nibbles; digit i at [4i+3:4i]
// - oDIG_VALID    out  NUM_DIGITS    digit i captured at least once since reset
// - oEV_VALID     out  1             event pending
// - oEV_IDX       out  3             digit index of the pending event
// - oEV_DIG       out  4             new nibble of the pending event
// - oERR          out  1             sticky: illegal pattern or multi-hot anode seen
// - oOVF          out  1             sticky: event dropped because one was already pending
// BEHAVIOUR
// - Reset: all outputs 0. Counter, sampler and FSM return to WAIT.
// - Input sampling:
//   - iSEG/iAN are registered once (sample regs).
//   - Stability counter clears when the new sample differs from the previous sample.
//   - Otherwise it increments, saturating at STABLE_CYCLES.
// - FSM:
//   - WAIT: sampled iAN is not exactly one bit low.
//     - All-high (blanking) is legal and does not raise an error.
//     - Two or more bits low sets oERR.
//     - Go to SETTLE when exactly one bit is low.
//   - SETTLE: counting.
//     - Any sample change returns to SETTLE with counter 0, or to WAIT if iAN is no longer one-hot.
//     - When the counter reaches STABLE_CYCLES, perform the capture and go to HELD.
//   - HELD: digit already captured. No further capture until the sample changes (then SETTLE/WAIT).
// - Latency: iSEG/iAN steady from edge k gives an updated oDIGITS after edge k+STABLE_CYCLES+1.
// - Decode table (iSEG -> nibble):
//   - 1111001->1, 0100100->2, 0110000->3, 0011001->4
//   - 0010010->5, 0000010->6, 1111000->7, 0000000->8
//   - 0011000->9, 0001000->A, 0000011->B, 1000110->C
//   - 0100001->D, 0000110->E, 0001110->F
//   - 1111111->0 (blank encodes 0)
//   - Any other pattern is illegal.
// - Capture for digit i (i = index of the low anode bit):
//   - Legal pattern: write oDIGITS[i] and set oDIG_VALID[i].
//     - An event is generated if oDIG_VALID[i] was 0 or the nibble differs from the stored one.
//   - Illegal pattern: set oERR. oDIGITS[i] and oDIG_VALID[i] are unchanged. No event.
// - Event stream (single-entry buffer):
//   - oEV_VALID/IDX/DIG hold stable until oEV_VALID & iEV_READY.
//   - New event while pending and not accepted this cycle: the event is dropped and oOVF is set.
//     oDIGITS is still updated.
//   - Accept and new event in the same cycle: oEV_VALID stays 1 and the payload takes the new event.
// - iCLR_ERR clears oERR/oOVF next edge. A simultaneous new error wins, so the flag stays 1.
// - Reset mid-SETTLE or with an event pending:
//   - Event discarded; oDIGITS and oDIG_VALID cleared.
//   - A capture needs a full STABLE_CYCLES window after reset deasserts.
// TESTING
// - Event path: iAN=111110, iSEG=0010010 held 6 cycles, iEV_READY=0
//   -> oDIGITS[3:0]=5, oDIG_VALID=000001, oEV_VALID=1, IDX=0, DIG=5.
// - Timing window (STABLE_CYCLES=4): toggle iSEG every 3 cycles -> no capture, oEV_VALID=0.
//   - Then hold -> capture exactly STABLE_CYCLES+1 edges after the last change.
// - Blank and repeat: iAN=101111, iSEG=1111111 -> digit 4 = 0, event raised.
//   - Re-show the same pattern after a blank gap -> no new event.
// - Error flag: iSEG=1010101 on digit 2 -> oERR=1, oDIG_VALID[2]=0.
//   - iAN=110011 -> oERR=1.
//   - iCLR_ERR pulse -> oERR=0.
// - Overflow: two digits captured with iEV_READY=0 -> first event held, oOVF=1.
//   - Both oDIGITS fields updated.
//   - iEV_READY=1 with a same-cycle capture -> payload replaced, oEV_VALID stays 1.
// - Reset: assert reset with an event pending -> all outputs 0 next edge.
//   - After release, a capture needs a full STABLE_CYCLES window.

Source files
------------

// File: rtl/seg7_scan_decoder_if.sv
// Bus bundle for the 7-segment scan decoder: the scanned display lines being
// monitored, the error-clear strobe, and the decoded readback / event stream.
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 6
);
  logic [6:0]              iSEG;
  logic [NUM_DIGITS-1:0]   iAN;
  logic                    iCLR_ERR;
  logic                    iEV_READY;
  logic [4*NUM_DIGITS-1:0] oDIGITS;
  logic [NUM_DIGITS-1:0]   oDIG_VALID;
  logic                    oEV_VALID;
  logic [2:0]              oEV_IDX;
  logic [3:0]              oEV_DIG;
  logic                    oERR;
  logic                    oOVF;

  modport master (
    output iSEG, iAN, iCLR_ERR, iEV_READY,
    input  oDIGITS, oDIG_VALID, oEV_VALID, oEV_IDX, oEV_DIG, oERR, oOVF
  );

  modport slave (
    input  iSEG, iAN, iCLR_ERR, iEV_READY,
    output oDIGITS, oDIG_VALID, oEV_VALID, oEV_IDX, oEV_DIG, oERR, oOVF
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Readback decoder for a multiplexed active-low 7-segment display.
// Samples the segment/anode bus, waits for a digit to be stable for
// STABLE_CYCLES further samples, decodes the pattern back to a hex nibble and
// reports per-digit changes through a single-entry valid/ready event buffer.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input logic                clk,
  input logic                reset,
  seg7_scan_decoder_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_HELD} state_t;

  // Returns {legal, nibble}; the blank pattern reads back as 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b1111111: return 5'b1_0000;
      7'b1111001: return 5'b1_0001;
      7'b0100100: return 5'b1_0010;
      7'b0110000: return 5'b1_0011;
      7'b0011001: return 5'b1_0100;
      7'b0010010: return 5'b1_0101;
      7'b0000010: return 5'b1_0110;
      7'b1111000: return 5'b1_0111;
      7'b0000000: return 5'b1_1000;
      7'b0011000: return 5'b1_1001;
      7'b0001000: return 5'b1_1010;
      7'b0000011: return 5'b1_1011;
      7'b1000110: return 5'b1_1100;
      7'b0100001: return 5'b1_1101;
      7'b0000110: return 5'b1_1110;
      7'b0001110: return 5'b1_1111;
      default:    return 5'b0_0000;
    endcase
  endfunction

  // Stability counter increment, saturating once the window is complete.
  function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] c);
    if (c >= CW'(STABLE_CYCLES)) return CW'(STABLE_CYCLES);
    return c + 1'b1;
  endfunction

  function automatic logic [3:0] low_count(input logic [NUM_DIGITS-1:0] an);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) n = n + {3'b000, ~an[i]};
    return n;
  endfunction

  function automatic logic [2:0] low_index(input logic [NUM_DIGITS-1:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) if (!an[i]) idx = 3'(i);
    return idx;
  endfunction

  logic [6:0]              seg_p0;
  logic [NUM_DIGITS-1:0]   an_p0;
  logic [CW-1:0]           cnt_p0;
  logic [3:0]              nlow_p0;
  logic                    onehot_p0;
  logic                    multi_p0;
  logic [2:0]              idx_p0;
  logic [4:0]              dec_p0;
  logic                    legal_p0;
  logic [3:0]              nib_p0;
  logic                    stable_p0;

  state_t                  state;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   dvld_q;
  logic                    ev_vld_q;
  logic [2:0]              ev_idx_q;
  logic [3:0]              ev_dig_q;
  logic                    err_q;
  logic                    ovf_q;

  logic [3:0]              cur_nib;
  logic                    cur_vld;
  logic                    cap;
  logic                    cap_wr;
  logic                    cap_bad;
  logic                    new_ev;
  logic                    err_set;

  assign nlow_p0   = low_count(an_p0);
  assign onehot_p0 = (nlow_p0 == 4'd1);
  assign multi_p0  = (nlow_p0 >= 4'd2);
  assign idx_p0    = low_index(an_p0);
  assign dec_p0    = seg_decode(seg_p0);
  assign legal_p0  = dec_p0[4];
  assign nib_p0    = dec_p0[3:0];
  assign stable_p0 = (cnt_p0 == CW'(STABLE_CYCLES));

  // Sample stage: register the bus once and count consecutive identical samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_p0 <= '1;
      an_p0  <= '1;
      cnt_p0 <= '0;
    end else begin
      seg_p0 <= bus.iSEG;
      an_p0  <= bus.iAN;
      if (bus.iSEG != seg_p0 || bus.iAN != an_p0) cnt_p0 <= '0;
      else                                        cnt_p0 <= cnt_sat_inc(cnt_p0);
    end
  end

  // Look up the currently stored nibble for the digit being shown.
  always_comb begin
    cur_nib = 4'h0;
    cur_vld = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_p0 == 3'(i)) begin
        cur_nib = digits_q[4*i +: 4];
        cur_vld = dvld_q[i];
      end
    end
  end

  assign cap     = (state == ST_SETTLE) && onehot_p0 && stable_p0;
  assign cap_wr  = cap && legal_p0;
  assign cap_bad = cap && !legal_p0;
  assign new_ev  = cap_wr && (!cur_vld || (cur_nib != nib_p0));
  assign err_set = cap_bad || multi_p0;

  // Capture FSM with registered digit store, event buffer and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_WAIT;
      digits_q <= '0;
      dvld_q   <= '0;
      ev_vld_q <= 1'b0;
      ev_idx_q <= 3'd0;
      ev_dig_q <= 4'd0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        ST_WAIT:   if (onehot_p0) state <= ST_SETTLE;
        ST_SETTLE: begin
          if (!onehot_p0)     state <= ST_WAIT;
          else if (stable_p0) state <= ST_HELD;
        end
        // A zero count means the sample just changed: re-arm.
        ST_HELD:   if (cnt_p0 == '0) state <= onehot_p0 ? ST_SETTLE : ST_WAIT;
        default:   state <= ST_WAIT;
      endcase

      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_wr && idx_p0 == 3'(i)) begin
          digits_q[4*i +: 4] <= nib_p0;
          dvld_q[i]          <= 1'b1;
        end
      end

      // A pending event is only replaced when it is being accepted this cycle.
      if (new_ev) begin
        if (!ev_vld_q || bus.iEV_READY) begin
          ev_vld_q <= 1'b1;
          ev_idx_q <= idx_p0;
          ev_dig_q <= nib_p0;
        end
      end else if (ev_vld_q && bus.iEV_READY) begin
        ev_vld_q <= 1'b0;
      end

      err_q <= err_set || (err_q && !bus.iCLR_ERR);
      ovf_q <= (new_ev && ev_vld_q && !bus.iEV_READY) || (ovf_q && !bus.iCLR_ERR);
    end
  end

  assign bus.oDIGITS    = digits_q;
  assign bus.oDIG_VALID = dvld_q;
  assign bus.oEV_VALID  = ev_vld_q;
  assign bus.oEV_IDX    = ev_idx_q;
  assign bus.oEV_DIG    = ev_dig_q;
  assign bus.oERR       = err_q;
  assign bus.oOVF       = ovf_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder: directed scenarios with literal
// expectations, then randomized scan traffic, all compared every cycle
// against a behavioural model of the readback rules.
module tb_seg7_scan_decoder;

  localparam int ND = 6;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Segment patterns indexed by the nibble they encode.
  logic [6:0] pat [16] = '{7'b1111111, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model state.
  logic [6:0]    m_seg = 7'h7F;
  logic [ND-1:0] m_an  = '1;
  int            m_rl  = 1;
  int            m_dig [ND];
  bit            m_dv  [ND];
  bit            m_evv = 0;
  int            m_evi = 0;
  int            m_evd = 0;
  bit            m_err = 0;
  bit            m_ovf = 0;

  logic [4*ND-1:0] exp_digits;
  logic [ND-1:0]   exp_dv;

  // Reference model update on each edge, then compare DUT outputs after it settles.
  always @(posedge clk) begin
    int lows, idx, nib;
    bit legal, newev, eset, oset;
    if (reset) begin
      for (int i = 0; i < ND; i++) begin m_dig[i] = 0; m_dv[i] = 0; end
      m_evv = 0; m_evi = 0; m_evd = 0; m_err = 0; m_ovf = 0;
      m_seg = 7'h7F; m_an = '1; m_rl = 1;
    end else begin
      lows = 0; idx = 0;
      for (int i = 0; i < ND; i++) if (!m_an[i]) begin lows++; idx = i; end
      newev = 0; oset = 0;
      eset  = (lows >= 2);
      // Capture once, when the shown digit has been seen STABLE_CYCLES+1 times in a row.
      if (m_rl == SC + 1 && lows == 1) begin
        legal = 0; nib = 0;
        for (int j = 0; j < 16; j++) if (pat[j] == m_seg) begin legal = 1; nib = j; end
        if (!legal) eset = 1;
        else begin
          newev = !m_dv[idx] || (m_dig[idx] != nib);
          m_dig[idx] = nib;
          m_dv[idx]  = 1;
        end
      end
      if (newev) begin
        if (!m_evv || bus.iEV_READY) begin m_evv = 1; m_evi = idx; m_evd = nib; end
        else oset = 1;
      end else if (m_evv && bus.iEV_READY) begin
        m_evv = 0;
      end
      m_err = eset || (m_err && !bus.iCLR_ERR);
      m_ovf = oset || (m_ovf && !bus.iCLR_ERR);
      if (bus.iSEG == m_seg && bus.iAN == m_an) m_rl++;
      else begin m_seg = bus.iSEG; m_an = bus.iAN; m_rl = 1; end
    end
    for (int i = 0; i < ND; i++) begin
      exp_digits[4*i +: 4] = 4'(m_dig[i]);
      exp_dv[i]            = m_dv[i];
    end
    #1;
    chk("model oDIGITS",    32'(bus.oDIGITS),    32'(exp_digits));
    chk("model oDIG_VALID", 32'(bus.oDIG_VALID), 32'(exp_dv));
    chk("model oEV_VALID",  32'(bus.oEV_VALID),  32'(m_evv));
    if (m_evv) begin
      chk("model oEV_IDX", 32'(bus.oEV_IDX), 32'(m_evi));
      chk("model oEV_DIG", 32'(bus.oEV_DIG), 32'(m_evd));
    end
    chk("model oERR", 32'(bus.oERR), 32'(m_err));
    chk("model oOVF", 32'(bus.oOVF), 32'(m_ovf));
  end

  // Present a pattern for n clock edges; entered and left on a falling edge.
  task automatic hold(input logic [6:0] s, input logic [ND-1:0] a, input int n, input bit rnd_rdy);
    bus.iSEG = s;
    bus.iAN  = a;
    for (int c = 0; c < n; c++) begin
      if (rnd_rdy) bus.iEV_READY = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " oDIGITS"},    32'(bus.oDIGITS),    32'h0);
    chk({tag, " oDIG_VALID"}, 32'(bus.oDIG_VALID), 32'h0);
    chk({tag, " oEV_VALID"},  32'(bus.oEV_VALID),  32'h0);
    chk({tag, " oEV_IDX"},    32'(bus.oEV_IDX),    32'h0);
    chk({tag, " oEV_DIG"},    32'(bus.oEV_DIG),    32'h0);
    chk({tag, " oERR"},       32'(bus.oERR),       32'h0);
    chk({tag, " oOVF"},       32'(bus.oOVF),       32'h0);
  endtask

  initial begin
    logic [ND-1:0] an;
    logic [6:0]    sg;
    int            r;
    bus.iSEG = 7'h7F; bus.iAN = '1; bus.iCLR_ERR = 1'b0; bus.iEV_READY = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // Event path and capture latency on digit 0.
    hold(7'b0010010, 6'b111110, 5, 0);
    chk("lat early dv", 32'(bus.oDIG_VALID), 32'h0);
    hold(7'b0010010, 6'b111110, 1, 0);
    chk("ev digit0",  32'(bus.oDIGITS[3:0]), 32'h5);
    chk("ev dv",      32'(bus.oDIG_VALID),   32'b000001);
    chk("ev valid",   32'(bus.oEV_VALID),    32'h1);
    chk("ev idx",     32'(bus.oEV_IDX),      32'h0);
    chk("ev dig",     32'(bus.oEV_DIG),      32'h5);

    // Timing window: changes every 3 samples never settle.
    bus.iEV_READY = 1'b1;
    for (int t = 0; t < 4; t++) hold((t % 2 == 0) ? 7'b1111001 : 7'b0100100, 6'b111101, 3, 0);
    chk("win no ev",  32'(bus.oEV_VALID),     32'h0);
    chk("win no dv1", 32'(bus.oDIG_VALID[1]), 32'h0);
    hold(7'b0100100, 6'b111101, 2, 0);
    chk("win edge-1", 32'(bus.oDIG_VALID[1]), 32'h0);
    hold(7'b0100100, 6'b111101, 1, 0);
    chk("win capture", 32'(bus.oDIGITS[7:4]), 32'h2);

    // Blank pattern decodes to 0; re-showing it raises no event.
    hold(7'b1111111, 6'b101111, 6, 0);
    chk("blank dig4",  32'(bus.oDIGITS[19:16]), 32'h0);
    chk("blank dv4",   32'(bus.oDIG_VALID[4]),  32'h1);
    chk("blank ev",    32'(bus.oEV_VALID),      32'h1);
    chk("blank idx",   32'(bus.oEV_IDX),        32'h4);
    hold(7'b1111111, 6'b111111, 3, 0);
    hold(7'b1111111, 6'b101111, 6, 0);
    chk("repeat no ev", 32'(bus.oEV_VALID), 32'h0);

    // Error flag: illegal pattern, clear, multi-hot anodes, clear racing a new error.
    hold(7'b1010101, 6'b111011, 6, 0);
    chk("illegal err", 32'(bus.oERR),          32'h1);
    chk("illegal dv2", 32'(bus.oDIG_VALID[2]), 32'h0);
    bus.iCLR_ERR = 1'b1;
    hold(7'h7F, 6'b111111, 1, 0);
    bus.iCLR_ERR = 1'b0;
    chk("clr err", 32'(bus.oERR), 32'h0);
    hold(7'h7F, 6'b110011, 2, 0);
    chk("multi err", 32'(bus.oERR), 32'h1);
    bus.iCLR_ERR = 1'b1;
    hold(7'h7F, 6'b111111, 1, 0);
    chk("err wins clr", 32'(bus.oERR), 32'h1);
    hold(7'h7F, 6'b111111, 1, 0);
    bus.iCLR_ERR = 1'b0;
    chk("clr err 2", 32'(bus.oERR), 32'h0);

    // Overflow with the buffer full, then accept and replace in one cycle.
    bus.iEV_READY = 1'b0;
    hold(7'b0110000, 6'b111110, 6, 0);
    hold(7'b1111000, 6'b111101, 6, 0);
    chk("ovf flag",  32'(bus.oOVF),          32'h1);
    chk("ovf idx",   32'(bus.oEV_IDX),       32'h0);
    chk("ovf dig",   32'(bus.oEV_DIG),       32'h3);
    chk("ovf d0",    32'(bus.oDIGITS[3:0]),  32'h3);
    chk("ovf d1",    32'(bus.oDIGITS[7:4]),  32'h7);
    hold(7'b0000000, 6'b111011, 5, 0);
    bus.iEV_READY = 1'b1;
    hold(7'b0000000, 6'b111011, 1, 0);
    chk("repl valid", 32'(bus.oEV_VALID), 32'h1);
    chk("repl idx",   32'(bus.oEV_IDX),   32'h2);
    chk("repl dig",   32'(bus.oEV_DIG),   32'h8);

    // Reset mid-settle with an event pending, then a full window afterwards.
    bus.iEV_READY = 1'b0;
    hold(7'b0011000, 6'b110111, 2, 0);
    reset = 1'b1;
    hold(7'b0011000, 6'b110111, 1, 0);
    chk_all_zero("mid reset");
    reset = 1'b0;
    hold(7'b0011000, 6'b110111, 5, 0);
    chk("post rst early", 32'(bus.oDIG_VALID), 32'h0);
    hold(7'b0011000, 6'b110111, 1, 0);
    chk("post rst dv",  32'(bus.oDIG_VALID),     32'b001000);
    chk("post rst dig", 32'(bus.oDIGITS[15:12]), 32'h9);

    // Randomized scan traffic against the model.
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      an = ~(ND'(1) << $urandom_range(0, ND - 1));
      else if (r < 88) an = '1;
      else             an = ~((ND'(1) << $urandom_range(0, ND - 1)) | (ND'(1) << $urandom_range(0, ND - 1)));
      if ($urandom_range(0, 9) < 8) sg = pat[$urandom_range(0, 15)];
      else                          sg = 7'($urandom);
      bus.iCLR_ERR = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 79) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      hold(sg, an, $urandom_range(1, 9), 1);
    end
    bus.iCLR_ERR = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
